// File: rtl/lfsr_pkg.sv
// Shared constants, state type and step function for the LFSR random-number scheduler.
package lfsr_pkg;

   localparam int LFSR_W = 32;
   localparam int CNT_W  = 6;

   localparam logic [LFSR_W-1:0] DEFAULT_POLY = 32'h8020_0003;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_2468;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      ADVANCE = 1'b1
   } state_e;

   // One Galois step: shift right, fold the feedback mask in when the bit shifted out is 1.
   function automatic logic [LFSR_W-1:0] galois_next(input logic [LFSR_W-1:0] cur,
                                                     input logic [LFSR_W-1:0] poly);
      return cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
   endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR register with load and step; a zero load value is replaced by SEED
// so the register can never enter the all-zero lock-up state.
module lfsr32_galois
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
   parameter logic [LFSR_W-1:0] POLY = DEFAULT_POLY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_data,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] lfsr_q;

   // Next value: a load wins over a step; with neither, the register holds.
   always_comb begin
      // NOTE: default first so every path assigns lfsr_d and no latch is inferred.
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (load_data == '0) ? SEED : load_data;
      end else if (step) begin
         lfsr_d = galois_next(lfsr_q, POLY);
      end
   end

   // LFSR register, synchronous reset to SEED.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/lfsr_rnd_scheduler.sv
// Round-robin scheduler handing out one LFSR word per grant, then advancing the LFSR
// STEPS states (busy) before the next grant. seed_load reseeds and aborts an advance.
module lfsr_rnd_scheduler
   import lfsr_pkg::*;
#(
   parameter int                N_REQ = 4,
   parameter int                STEPS = 1,
   parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
   parameter logic [LFSR_W-1:0] POLY  = DEFAULT_POLY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_data,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic              rnd_valid,
   output logic [LFSR_W-1:0] rnd_data,
   output logic              busy
);

   localparam int PTR_W = $clog2(N_REQ);

   state_e            state_d, state_q;
   logic [PTR_W-1:0]  ptr_d, ptr_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [N_REQ-1:0]  gnt_d, gnt_q;
   logic              rnd_valid_d, rnd_valid_q;
   logic [LFSR_W-1:0] rnd_data_d, rnd_data_q;
   logic              busy_d, busy_q;

   logic [LFSR_W-1:0] lfsr;
   logic              lfsr_step;
   logic              win_found;
   logic [PTR_W-1:0]  win_idx;

   // (base + offs) mod N_REQ for offs < N_REQ; works for non-power-of-two N_REQ.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= N_REQ) begin
         sum = sum - N_REQ;
      end
      return PTR_W'(sum);
   endfunction

   // The LFSR only moves while advancing; seed_load is honoured in either state.
   assign lfsr_step = (state_q == ADVANCE);

   lfsr32_galois #(
      .SEED (SEED),
      .POLY (POLY)
   ) u_lfsr (
      .clock     (clock),
      .reset     (reset),
      .load      (seed_load),
      .load_data (seed_data),
      .step      (lfsr_step),
      .q         (lfsr)
   );

   // Round-robin search: first requesting index at or above ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req[wrap_add(ptr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(ptr_q, i);
         end
      end
   end

   // FSM next state and next registered outputs; gnt/rnd_valid default to a one-cycle pulse.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      rnd_valid_d = 1'b0;
      rnd_data_d  = rnd_data_q;
      unique case (state_q)
         IDLE: begin
            if (!seed_load && win_found) begin
               gnt_d[win_idx] = 1'b1;
               rnd_valid_d    = 1'b1;
               rnd_data_d     = lfsr;
               ptr_d          = wrap_add(win_idx, 1);
               cnt_d          = CNT_W'(STEPS);
               state_d        = ADVANCE;
            end
         end
         ADVANCE: begin
            if (seed_load) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == ADVANCE);
   end

   // Single state/output register bank; reset overrides seed_load and any advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         rnd_valid_q <= 1'b0;
         rnd_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rnd_valid_q <= rnd_valid_d;
         rnd_data_q  <= rnd_data_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign rnd_valid = rnd_valid_q;
   assign rnd_data  = rnd_data_q;
   assign busy      = busy_q;

endmodule
